// File: rtl/uart_bus_pkg.sv
// Shared types and constants for the UART debug bus master.
// Bus widths fall back to the 32-bit / 4-slave-bit layout when the shared defines are absent.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SLAVE_WIDTH
`define SLAVE_WIDTH 4
`endif

package uart_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        REPLY
    } state_t;

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    localparam logic [2:0] MODE_WORD = 3'b010;

    function automatic int div_of(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_bus_rx.sv
// 8N1 receiver: two-flop synchronizer, start-bit qualification at mid-bit,
// LSB-first sampling; pulses byte_valid or frame_err after the stop bit.
module uart_bus_rx #(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t     state_reg, state_next;
    logic [1:0]    sync_reg;
    logic          prev_reg;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          valid_reg, valid_next;
    logic          err_reg, err_next;
    logic          rx_s;
    logic          rx_fall;

    assign rx_s    = sync_reg[1];
    assign rx_fall = prev_reg & ~rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg  <= 2'b11;
            prev_reg  <= 1'b1;
            state_reg <= RX_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], rx};
            prev_reg  <= rx_s;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        valid_next = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                if (rx_fall) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end
            RX_START: begin
                // A glitch that is already high again by mid-bit is not a start bit
                if (cnt_reg == HALF_M1) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_reg == FULL_M1) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = RX_STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_reg == FULL_M1) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                    valid_next = rx_s;
                    err_next   = ~rx_s;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_reg;
    assign byte_data  = shift_reg;
    assign frame_err  = err_reg;

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven debug initiator: parses 'W'/'R' frames from the host, runs one word
// access on the uib bus and serializes the reply back on uart_tx.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SLAVE_WIDTH
`define SLAVE_WIDTH 4
`endif

module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int BYTE_TIMEOUT = div_of(CLK_FREQ, BAUD) * 40
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            uart_rx,
    output logic                            uart_tx,
    input  logic [`XLEN-1:0]                master_dat_i,
    input  logic                            master_ready,
    output logic [`XLEN-1:0]                master_dat_o,
    output logic [`XLEN-`SLAVE_WIDTH-1:0]   master_addr,
    output logic [`SLAVE_WIDTH-1:0]         master_num,
    output logic [2:0]                      master_mode,
    output logic                            master_wen,
    output logic                            master_req,
    output logic                            busy
);

    localparam int DIV = div_of(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(DIV) + 1;
    localparam int TW  = $clog2(BYTE_TIMEOUT) + 1;
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
    localparam logic [TW-1:0] TMO_M1 = TW'(BYTE_TIMEOUT - 1);

    state_t             state_reg, state_next;
    logic [1:0]         idx_reg, idx_next;
    logic               wen_reg, wen_next;
    logic [`XLEN-1:0]   addr_reg, addr_next;
    logic [`XLEN-1:0]   data_reg, data_next;
    logic [`XLEN-1:0]   rsp_reg, rsp_next;
    logic [1:0]         rsp_last_reg, rsp_last_next;
    logic [TW-1:0]      tmo_reg, tmo_next;
    logic               req_reg, req_next;
    logic [CW-1:0]      tx_cnt_reg, tx_cnt_next;
    logic [3:0]         tx_bit_reg, tx_bit_next;
    logic [1:0]         tx_byte_reg, tx_byte_next;
    logic               tx_reg;
    logic [7:0]         tx_cur_byte;
    logic               tx_bit_val;

    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               rx_err;

    uart_bus_rx #(.DIV(DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (uart_rx),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_err  (rx_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            wen_reg      <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            rsp_reg      <= '0;
            rsp_last_reg <= '0;
            tmo_reg      <= '0;
            req_reg      <= 1'b0;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_byte_reg  <= '0;
            tx_reg       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            wen_reg      <= wen_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            rsp_reg      <= rsp_next;
            rsp_last_reg <= rsp_last_next;
            tmo_reg      <= tmo_next;
            req_reg      <= req_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_byte_reg  <= tx_byte_next;
            tx_reg       <= (state_reg == REPLY) ? tx_bit_val : 1'b1;
        end
    end

    // Bit 0 is the start bit, 1..8 the data bits LSB first, 9 the stop bit
    assign tx_cur_byte = rsp_reg[{tx_byte_reg, 3'b000} +: 8];

    always_comb begin
        tx_bit_val = 1'b1;
        if (tx_bit_reg == 4'd0) begin
            tx_bit_val = 1'b0;
        end else if (tx_bit_reg <= 4'd8) begin
            tx_bit_val = tx_cur_byte[3'(tx_bit_reg - 4'd1)];
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        wen_next      = wen_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        rsp_next      = rsp_reg;
        rsp_last_next = rsp_last_reg;
        tmo_next      = '0;
        req_next      = req_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_byte_next  = tx_byte_reg;
        case (state_reg)
            IDLE: begin
                idx_next     = '0;
                tx_cnt_next  = '0;
                tx_bit_next  = '0;
                tx_byte_next = '0;
                if (rx_valid) begin
                    if (rx_data == CMD_W || rx_data == CMD_R) begin
                        wen_next   = (rx_data == CMD_W);
                        state_next = ADDR;
                    end else begin
                        rsp_next      = {{(`XLEN-8){1'b0}}, RSP_ERR};
                        rsp_last_next = 2'd0;
                        state_next    = REPLY;
                    end
                end
            end
            ADDR: begin
                if (rx_err) begin
                    idx_next   = '0;
                    state_next = IDLE;
                end else if (rx_valid) begin
                    addr_next[{idx_reg, 3'b000} +: 8] = rx_data;
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        if (wen_reg) begin
                            state_next = DATA;
                        end else begin
                            req_next   = 1'b1;
                            state_next = BUS;
                        end
                    end
                end else if (tmo_reg == TMO_M1) begin
                    idx_next   = '0;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            DATA: begin
                if (rx_err) begin
                    idx_next   = '0;
                    state_next = IDLE;
                end else if (rx_valid) begin
                    data_next[{idx_reg, 3'b000} +: 8] = rx_data;
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        req_next   = 1'b1;
                        state_next = BUS;
                    end
                end else if (tmo_reg == TMO_M1) begin
                    idx_next   = '0;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            BUS: begin
                // No timeout here: a hung slave keeps the block busy until reset
                if (master_ready && req_reg) begin
                    req_next      = 1'b0;
                    rsp_next      = wen_reg ? {{(`XLEN-8){1'b0}}, RSP_OK} : master_dat_i;
                    rsp_last_next = wen_reg ? 2'd0 : 2'd3;
                    state_next    = REPLY;
                end
            end
            REPLY: begin
                if (tx_cnt_reg == DIV_M1) begin
                    tx_cnt_next = '0;
                    if (tx_bit_reg == 4'd9) begin
                        tx_bit_next = '0;
                        if (tx_byte_reg == rsp_last_reg) begin
                            tx_byte_next = '0;
                            state_next   = IDLE;
                        end else begin
                            tx_byte_next = tx_byte_reg + 2'd1;
                        end
                    end else begin
                        tx_bit_next = tx_bit_reg + 4'd1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign uart_tx      = tx_reg;
    assign master_req   = req_reg;
    assign master_wen   = wen_reg;
    assign master_dat_o = data_reg;
    assign master_num   = addr_reg[`XLEN-1 -: `SLAVE_WIDTH];
    assign master_addr  = addr_reg[`XLEN-`SLAVE_WIDTH-1:0];
    assign master_mode  = MODE_WORD;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: host frames in, bus slave model and TX decoder check results.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SLAVE_WIDTH
`define SLAVE_WIDTH 4
`endif

module tb_uart_bus_master;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int DIV      = 16;
    localparam int AW       = `XLEN - `SLAVE_WIDTH;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic                    wen;
        logic [`SLAVE_WIDTH-1:0] num;
        logic [AW-1:0]           addr;
        logic [31:0]             wdata;
        logic [31:0]             rdata;
    } bus_t;

    logic                    clk;
    logic                    rst;
    logic                    uart_rx;
    logic                    uart_tx;
    logic [`XLEN-1:0]        master_dat_i;
    logic                    master_ready;
    logic [`XLEN-1:0]        master_dat_o;
    logic [AW-1:0]           master_addr;
    logic [`SLAVE_WIDTH-1:0] master_num;
    logic [2:0]              master_mode;
    logic                    master_wen;
    logic                    master_req;
    logic                    busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_tx[$];
    bus_t       exp_bus[$];
    logic       bus_en      = 1'b1;
    logic       spur_ready  = 1'b0;
    logic       mon_active  = 1'b0;
    int         ready_delay = 3;
    logic [7:0] rb;
    logic [7:0] eb_tx;
    bq_t        fr;

    uart_bus_master #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .uart_tx      (uart_tx),
        .master_dat_i (master_dat_i),
        .master_ready (master_ready),
        .master_dat_o (master_dat_o),
        .master_addr  (master_addr),
        .master_num   (master_num),
        .master_mode  (master_mode),
        .master_wen   (master_wen),
        .master_req   (master_req),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic good_stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = good_stop;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input bq_t f);
        $display("host -> %0d byte frame, first %02h", f.size(), f[0]);
        foreach (f[i]) send_byte(f[i], 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        logic done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_tx.size() == 0 && !mon_active) done = 1'b1;
        end
        check_eq("idle_wait", 32'(done), 32'd1);
    endtask

    // TX line decoder: every byte the DUT sends is matched against the reply queue
    initial begin
        forever begin
            @(negedge uart_tx);
            if (!rst) begin
                mon_active = 1'b1;
                repeat (DIV / 2) @(negedge clk);
                check_eq("tx_start", 32'(uart_tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    rb[i] = uart_tx;
                end
                repeat (DIV) @(negedge clk);
                check_eq("tx_stop", 32'(uart_tx), 32'd1);
                $display("dut -> tx byte %02h", rb);
                if (exp_tx.size() == 0) begin
                    check_eq("tx_extra", 32'(rb), 32'h100);
                end else begin
                    eb_tx = exp_tx.pop_front();
                    check_eq("tx_byte", 32'(rb), 32'(eb_tx));
                end
                mon_active = 1'b0;
            end
        end
    end

    // uib slave model: checks each request against the bus queue and answers after ready_delay
    initial begin
        bus_t                    eb;
        logic                    stable;
        logic [AW-1:0]           sa;
        logic [`SLAVE_WIDTH-1:0] sn;
        logic [`XLEN-1:0]        sd;
        logic                    sw;
        master_ready = 1'b0;
        master_dat_i = '0;
        forever begin
            @(negedge clk);
            if (spur_ready) begin
                master_ready = 1'b1;
                master_dat_i = 32'hFFFF_FFFF;
                @(negedge clk);
                master_ready = 1'b0;
                master_dat_i = '0;
                spur_ready   = 1'b0;
            end else if (bus_en && !rst && master_req === 1'b1) begin
                $display("bus req wen=%0d num=%h addr=%h dat_o=%h", master_wen, master_num, master_addr, master_dat_o);
                eb = '0;
                if (exp_bus.size() == 0) begin
                    check_eq("bus_unexp", 32'(master_req), 32'd0);
                end else begin
                    eb = exp_bus.pop_front();
                    check_eq("bus_wen", 32'(master_wen), 32'(eb.wen));
                    check_eq("bus_num", 32'(master_num), 32'(eb.num));
                    check_eq("bus_addr", 32'(master_addr), 32'(eb.addr));
                    check_eq("bus_mode", 32'(master_mode), 32'd2);
                    if (eb.wen) check_eq("bus_dat_o", master_dat_o, eb.wdata);
                end
                sa = master_addr; sn = master_num; sd = master_dat_o; sw = master_wen;
                stable = 1'b1;
                for (int i = 0; i < ready_delay; i++) begin
                    @(negedge clk);
                    stable &= (master_req === 1'b1) && (master_addr === sa) && (master_num === sn)
                              && (master_dat_o === sd) && (master_wen === sw);
                end
                check_eq("bus_stable", 32'(stable), 32'd1);
                master_dat_i = eb.rdata;
                master_ready = 1'b1;
                @(negedge clk);
                master_ready = 1'b0;
                master_dat_i = '0;
                check_eq("req_drop", 32'(master_req), 32'd0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(uart_tx), 32'd1);
        check_eq("rst_req", 32'(master_req), 32'd0);
        check_eq("rst_wen", 32'(master_wen), 32'd0);
        check_eq("rst_dat_o", master_dat_o, 32'd0);
        check_eq("rst_addr", 32'(master_addr), 32'd0);
        check_eq("rst_num", 32'(master_num), 32'd0);
        check_eq("rst_mode", 32'(master_mode), 32'd2);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Write to 0x20000010
        exp_bus.push_back('{wen: 1'b1, num: 4'h2, addr: 28'h0000010, wdata: 32'hDEADBEEF, rdata: 32'h0});
        exp_tx.push_back(8'h4B);
        fr = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h20, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(fr);
        wait_idle(3000);

        // Read from 0x00000004, four reply bytes LSB first
        exp_bus.push_back('{wen: 1'b0, num: 4'h0, addr: 28'h0000004, wdata: 32'h0, rdata: 32'h12345678});
        exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
        fr = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
        send_frame(fr);
        wait_idle(3000);

        // Unknown command, then a normal read
        exp_tx.push_back(8'h3F);
        fr = '{8'hA5};
        send_frame(fr);
        wait_idle(1000);
        exp_bus.push_back('{wen: 1'b0, num: 4'h1, addr: 28'h0000008, wdata: 32'h0, rdata: 32'hCAFEF00D});
        exp_tx.push_back(8'h0D); exp_tx.push_back(8'hF0);
        exp_tx.push_back(8'hFE); exp_tx.push_back(8'hCA);
        fr = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h10};
        send_frame(fr);
        wait_idle(3000);

        // Partial frame then silence: still busy before the timeout, idle after it
        fr = '{8'h57, 8'h00, 8'h00};
        send_frame(fr);
        check_eq("tmo_busy_start", 32'(busy), 32'd1);
        repeat (500) @(negedge clk);
        check_eq("tmo_busy_before", 32'(busy), 32'd1);
        repeat (200) @(negedge clk);
        check_eq("tmo_busy_after", 32'(busy), 32'd0);
        exp_bus.push_back('{wen: 1'b0, num: 4'h0, addr: 28'h0000100, wdata: 32'h0, rdata: 32'h01020304});
        exp_tx.push_back(8'h04); exp_tx.push_back(8'h03);
        exp_tx.push_back(8'h02); exp_tx.push_back(8'h01);
        fr = '{8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
        send_frame(fr);
        wait_idle(3000);

        // Framing error in the middle of the address
        send_byte(8'h52, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        check_eq("ferr_idle", 32'(busy), 32'd0);
        repeat (300) @(negedge clk);
        check_eq("ferr_no_reply", 32'(exp_tx.size()) + 32'(mon_active), 32'd0);

        // Asynchronous reset while a request is outstanding
        bus_en = 1'b0;
        fr = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h30};
        send_frame(fr);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (master_req === 1'b1) seen = 1'b1;
        end
        check_eq("rst_req_seen", 32'(seen), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_req", 32'(master_req), 32'd0);
        check_eq("arst_tx", 32'(uart_tx), 32'd1);
        check_eq("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_en = 1'b1;
        repeat (5) @(negedge clk);

        // Slow slave: request fields must hold for 1000 cycles
        ready_delay = 1000;
        exp_bus.push_back('{wen: 1'b1, num: 4'h3, addr: 28'h0000040, wdata: 32'h0BADF00D, rdata: 32'h0});
        exp_tx.push_back(8'h4B);
        fr = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h30, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
        send_frame(fr);
        wait_idle(4000);
        ready_delay = 3;

        // Spurious ready while idle must not start anything
        spur_ready = 1'b1;
        for (int i = 0; i < 10 && spur_ready; i++) @(negedge clk);
        repeat (200) @(negedge clk);
        check_eq("spur_busy", 32'(busy), 32'd0);
        check_eq("spur_req", 32'(master_req), 32'd0);
        check_eq("spur_no_tx", 32'(exp_tx.size()) + 32'(mon_active), 32'd0);
        check_eq("bus_queue_empty", 32'(exp_bus.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
